// File: rtl/leg_solver.sv
`timescale 1ns/1ps
// leg_solver
//   Iterative right-triangle leg solver: leg_out = floor(sqrt(c^2 - a^2)).
//   The datapath has no multiplier. Squaring is done by shift-add, one
//   partial product per cycle. The root is a restoring digit-by-digit square
//   root that produces one result bit per cycle.
//
//   Build option:
//     LEG_SOLVER_ROUND_EN  when defined, the result is rounded to nearest
//                          instead of floored. Latency does not change.
//
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset
//     start    in   request, sampled only while idle
//     c_in     in   [7:0] hypotenuse
//     a_in     in   [7:0] known leg
//     busy     out  high whenever the FSM is not idle
//     done     out  one-cycle pulse; leg_out/invalid are valid while it is high
//     leg_out  out  [7:0] result, held until the next done
//     invalid  out  a_in > c_in on the last operation, held with leg_out
//
//   Latency from the accept edge to done: 25 cycles, or 17 cycles when the
//   operands are invalid.
module leg_solver (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] c_in,
   input  logic [7:0] a_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] leg_out,
   output logic       invalid
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SQ_C,
      ST_SQ_A,
      ST_SUB,
      ST_ROOT,
      ST_DONE
   } state_t;

   state_t      state;
   logic [7:0]  c_q;       // latched operands
   logic [7:0]  a_q;
   logic [15:0] acc;       // shift-add squaring accumulator
   logic [15:0] c_sq;
   logic [15:0] a_sq;
   logic [15:0] d_q;       // radicand; shifted left 2 bits per root step
   logic [17:0] rem_q;     // sqrt partial remainder
   logic [7:0]  root_q;    // sqrt partial root
   logic [2:0]  cnt;       // step counter, shared by squaring and root

   // ------------------------------------------------------------------
   // Squaring step: add (op << cnt) when bit cnt of op is set.
   // ------------------------------------------------------------------
   logic [7:0]  sq_op;
   logic [15:0] sq_term;
   logic [15:0] acc_nxt;

   always_comb begin
      sq_op   = (state == ST_SQ_A) ? a_q : c_q;
      sq_term = {8'h00, sq_op} << cnt;
      acc_nxt = sq_op[cnt] ? (acc + sq_term) : acc;
   end

   // ------------------------------------------------------------------
   // Restoring sqrt step. Bring down the next two radicand bits, then try
   // to subtract the trial value 4*root + 1.
   // ------------------------------------------------------------------
   logic [17:0] rem_sh;
   logic [17:0] trial;
   logic        take;
   logic [17:0] rem_nxt;
   logic [7:0]  root_nxt;
   logic [7:0]  leg_fin;

   always_comb begin
      rem_sh   = (rem_q << 2) | {16'h0000, d_q[15:14]};
      trial    = {8'h00, root_q, 2'b01};
      take     = (rem_sh >= trial);
      rem_nxt  = take ? (rem_sh - trial) : rem_sh;
      root_nxt = {root_q[6:0], take};
`ifdef LEG_SOLVER_ROUND_EN
      // D - r^2 > r means D > (r + 1/2)^2, so round up. D <= 255^2 keeps
      // root_nxt below 255 whenever this fires, so the increment cannot wrap.
      leg_fin  = (rem_nxt > {10'h000, root_nxt}) ? (root_nxt + 8'd1) : root_nxt;
`else
      leg_fin  = root_nxt;
`endif
   end

   // ------------------------------------------------------------------
   // Control FSM. Every output is a register.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         c_q     <= '0;
         a_q     <= '0;
         acc     <= '0;
         c_sq    <= '0;
         a_sq    <= '0;
         d_q     <= '0;
         rem_q   <= '0;
         root_q  <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         leg_out <= '0;
         invalid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  c_q   <= c_in;
                  a_q   <= a_in;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_SQ_C;
               end
            end

            ST_SQ_C: begin
               acc <= acc_nxt;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  c_sq  <= acc_nxt;
                  acc   <= '0;
                  state <= ST_SQ_A;
               end
            end

            ST_SQ_A: begin
               acc <= acc_nxt;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  a_sq  <= acc_nxt;
                  acc   <= '0;
                  state <= ST_SUB;
               end
            end

            ST_SUB: begin
               if (a_sq > c_sq) begin
                  // No real leg exists. Skip the root and report at once.
                  leg_out <= '0;
                  invalid <= 1'b1;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  d_q    <= c_sq - a_sq;
                  rem_q  <= '0;
                  root_q <= '0;
                  cnt    <= '0;
                  state  <= ST_ROOT;
               end
            end

            ST_ROOT: begin
               rem_q  <= rem_nxt;
               root_q <= root_nxt;
               d_q    <= {d_q[13:0], 2'b00};
               cnt    <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  leg_out <= leg_fin;
                  invalid <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/leg_solver.md
# leg_solver

Iterative right-triangle leg solver: given hypotenuse c and one leg a (8-bit unsigned), computes the other leg b = floor(sqrt(c² − a²)). It is the inverse companion of the combinational magnitude unit (sqrt(x² + y²)) and recovers a component from a magnitude plus the known component. The datapath is multiplier-free: shift-add squaring and a restoring digit-by-digit square root, one bit per cycle, with a start/busy/done handshake.

## Interface
- No parameters; all widths fixed at 8-bit operands, 16-bit internal.
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- c_in  in  8  hypotenuse, unsigned.
- a_in  in  8  known leg, unsigned.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; leg_out and invalid are valid while high.
- leg_out  out  8  result; held until the next done.
- invalid  out  1  a_in > c_in for the last operation; held with leg_out.

## Operation
- States: IDLE, SQ_C, SQ_A, SUB, ROOT, DONE.
- IDLE: on start=1, latch c_in and a_in, clear the accumulator and bit counter, go to SQ_C. start=0 stays IDLE.
- SQ_C: 8 steps, LSB first. Step i adds (c << i) to the 16-bit accumulator when c[i]=1. After step 7, store c² and go to SQ_A.
- SQ_A: same procedure for a. After step 7, store a² and go to SUB.
- SUB: if a² > c², set invalid=1 and leg_out=0, then go to DONE (ROOT skipped). Otherwise store D = c² − a² (16-bit, no wrap possible), clear root and remainder, go to ROOT.
- ROOT: restoring sqrt, 8 steps, result bits 7..0 in that order.
  - Each step shifts the next two bits of D into an 18-bit remainder.
  - Trial value = (root << 2) | 1. If remainder ≥ trial, subtract it and shift in 1; else shift in 0.
  - After step 7, load leg_out = root and invalid=0, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy: ignored; it is not queued.
- Inputs are used only at the latch edge. Changes afterwards have no effect.
- Range: D ≤ 255² = 65025, so the root always fits in 8 bits.

## Timing
- Reset (asynchronous, any state) forces IDLE, busy=0, done=0, leg_out=0, invalid=0, and clears internal registers. Reset mid-operation aborts it; no done is produced.
- Start accepted at edge N.
  - busy=1 from after edge N until the edge that leaves DONE.
  - Normal path: SQ_C at edges N+1..N+8, SQ_A at N+9..N+16, SUB at N+17, ROOT at N+18..N+25.
  - Normal path: done=1 in the cycle after edge N+25 (latency 25). IDLE after edge N+26.
  - Invalid path: done=1 in the cycle after edge N+17 (latency 17). IDLE after edge N+18.
- Back-to-back: start may be asserted in the cycle the block returns to IDLE. It is accepted on the next edge, giving 27 cycles minimum between normal accepts.
- leg_out and invalid are registered outputs. They change only on the edge that enters DONE.

## Configuration
- LEG_SOLVER_ROUND_EN defined: the result is rounded to nearest.
  - On the final ROOT step, if the final remainder > root, then leg_out = root + 1.
  - Cannot overflow, because D ≤ 255².
  - No added latency.
- LEG_SOLVER_ROUND_EN undefined: leg_out = floor(sqrt(D)).
- The invalid path is identical in both builds.

## Test plan
- c=5, a=3, start pulse at edge N → done in the cycle after N+25, leg_out=4, invalid=0, busy low after N+26.
- c=255, a=0 → leg_out=255. c=200, a=100 (D=30000) → leg_out=173. c=7, a=7 → leg_out=0, invalid=0.
- c=10, a=11 → done after edge N+17, invalid=1, leg_out=0. A following c=5, a=4 → leg_out=3, invalid=0.
- c=3, a=1 (D=8) → leg_out=2 without LEG_SOLVER_ROUND_EN, 3 with it. c=200, a=100 → 173 in both builds.
- Start asserted continuously with new operands every cycle during busy → only the first operands are used; the next accept occurs the edge after IDLE is re-entered.
- rst_n pulsed low at edge N+12 of an operation → outputs 0 immediately, no done pulse; a fresh start afterwards gives the correct result with standard latency.
